// File: rtl/pipelined_cpu.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with internal instruction memory,
// byte-wide data memory and register file; forwarding into EX, one-cycle load-use stall, ID-resolved branches.
module pipelined_cpu (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic jump_o,
  output logic branch_o,
  output logic data_o,
  output logic mux8_o
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_MUL = 6'h18;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    alusrc;
    alu_op_e aluop;
  } ctrl_t;

  logic [31:0] imem [0:255];
  logic [7:0]  dmem [0:31];
  logic [31:0] rf   [0:31];

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;

  ctrl_t       idex_ctrl_q, idex_ctrl_d;
  logic [4:0]  idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_dest_q, idex_dest_d;
  logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_imm_q, idex_imm_d;

  logic        exmem_regwrite_q, exmem_memwrite_q, exmem_memtoreg_q;
  logic [31:0] exmem_alu_q, exmem_store_q;
  logic [4:0]  exmem_rd_q;

  logic        memwb_regwrite_q, memwb_memtoreg_q;
  logic [31:0] memwb_alu_q, memwb_rdata_q;
  logic [4:0]  memwb_rd_q;

  logic        wb_we;
  logic [31:0] wb_data;

  // ---------------- ID ----------------
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_rs_val, id_rt_val, id_target;
  ctrl_t       id_ctrl;
  logic        id_is_beq, id_is_j, id_eq, id_take, stall;

  assign id_op    = ifid_instr_q[31:26];
  assign id_rs    = ifid_instr_q[25:21];
  assign id_rt    = ifid_instr_q[20:16];
  assign id_rd    = ifid_instr_q[15:11];
  assign id_funct = ifid_instr_q[5:0];
  assign id_imm   = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  // Write-through: a same-cycle WB write wins over the stored register value.
  always_comb begin
    id_rs_val = rf[id_rs];
    id_rt_val = rf[id_rt];
    if (wb_we && memwb_rd_q == id_rs) id_rs_val = wb_data;
    if (wb_we && memwb_rd_q == id_rt) id_rt_val = wb_data;
    if (id_rs == 5'd0) id_rs_val = '0;
    if (id_rt == 5'd0) id_rt_val = '0;
  end

  always_comb begin
    id_ctrl   = '0;
    id_dest   = '0;
    id_is_beq = 1'b0;
    id_is_j   = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        id_dest          = id_rd;
        id_ctrl.regwrite = 1'b1;
        case (id_funct)
          FN_ADD:  id_ctrl.aluop = ALU_ADD;
          FN_SUB:  id_ctrl.aluop = ALU_SUB;
          FN_AND:  id_ctrl.aluop = ALU_AND;
          FN_OR:   id_ctrl.aluop = ALU_OR;
          FN_MUL:  id_ctrl.aluop = ALU_MUL;
          default: id_ctrl.regwrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_dest          = id_rt;
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
      end
      OP_LW: begin
        id_dest          = id_rt;
        id_ctrl.regwrite = 1'b1;
        id_ctrl.memread  = 1'b1;
        id_ctrl.memtoreg = 1'b1;
        id_ctrl.alusrc   = 1'b1;
      end
      OP_SW: begin
        id_ctrl.memwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
      end
      OP_BEQ:  id_is_beq = 1'b1;
      OP_J:    id_is_j   = 1'b1;
      default: ;
    endcase
  end

  assign id_eq     = (id_rs_val == id_rt_val);
  assign id_take   = id_is_j | (id_is_beq & id_eq);
  assign id_target = id_is_j ? {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00}
                             : ifid_pc4_q + {id_imm[29:0], 2'b00};
  assign stall     = ~id_is_j & ~id_is_beq & idex_ctrl_q.memread &
                     ((idex_rt_q == id_rs) | (idex_rt_q == id_rt));

  assign jump_o   = id_is_j;
  assign branch_o = id_is_beq;
  assign data_o   = id_eq;
  assign mux8_o   = ~stall;

  // ---------------- IF / next state ----------------
  assign pc_plus4 = pc_q + 32'd4;

  // A taken branch/jump redirects even with start low so it is never lost.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (!stall) begin
      ifid_pc4_d = pc_plus4;
      if (id_take) begin
        pc_d         = id_target;
        ifid_instr_d = '0;
      end else if (start_i) begin
        pc_d         = pc_plus4;
        ifid_instr_d = imem[pc_q[9:2]];
      end else begin
        ifid_instr_d = '0;
      end
    end
  end

  always_comb begin
    idex_ctrl_d = '0;
    idex_rs_d   = '0;
    idex_rt_d   = '0;
    idex_dest_d = '0;
    idex_a_d    = '0;
    idex_b_d    = '0;
    idex_imm_d  = '0;
    if (!stall) begin
      idex_ctrl_d = id_ctrl;
      idex_rs_d   = id_rs;
      idex_rt_d   = id_rt;
      idex_dest_d = id_dest;
      idex_a_d    = id_rs_val;
      idex_b_d    = id_rt_val;
      idex_imm_d  = id_imm;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] ex_a, ex_b_reg, ex_b, ex_alu;
  logic        fwd_mem_a, fwd_mem_b, fwd_wb_a, fwd_wb_b;

  assign fwd_mem_a = exmem_regwrite_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_rs_q);
  assign fwd_mem_b = exmem_regwrite_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_rt_q);
  assign fwd_wb_a  = wb_we && (memwb_rd_q == idex_rs_q);
  assign fwd_wb_b  = wb_we && (memwb_rd_q == idex_rt_q);

  always_comb begin
    ex_a     = fwd_mem_a ? exmem_alu_q : (fwd_wb_a ? wb_data : idex_a_q);
    ex_b_reg = fwd_mem_b ? exmem_alu_q : (fwd_wb_b ? wb_data : idex_b_q);
    ex_b     = idex_ctrl_q.alusrc ? idex_imm_q : ex_b_reg;
    case (idex_ctrl_q.aluop)
      ALU_ADD: ex_alu = ex_a + ex_b;
      ALU_SUB: ex_alu = ex_a - ex_b;
      ALU_AND: ex_alu = ex_a & ex_b;
      ALU_OR:  ex_alu = ex_a | ex_b;
      ALU_MUL: ex_alu = ex_a * ex_b;
      default: ex_alu = '0;
    endcase
  end

  // ---------------- MEM ----------------
  logic [4:0]  mem_addr;
  logic [4:0]  lane_addr [0:3];
  logic [7:0]  lane_data [0:3];
  logic [31:0] mem_rdata;
  logic        mem_we;

  assign mem_addr = exmem_alu_q[4:0];
  assign mem_we   = exmem_memwrite_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = mem_addr + 5'(gi);
      assign lane_data[gi] = dmem[lane_addr[gi]];
    end
  endgenerate

  assign mem_rdata = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  // ---------------- WB ----------------
  assign wb_we   = memwb_regwrite_q && (memwb_rd_q != 5'd0);
  assign wb_data = memwb_memtoreg_q ? memwb_rdata_q : memwb_alu_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q             <= '0;
      ifid_instr_q     <= '0;
      ifid_pc4_q       <= '0;
      idex_ctrl_q      <= '0;
      idex_rs_q        <= '0;
      idex_rt_q        <= '0;
      idex_dest_q      <= '0;
      idex_a_q         <= '0;
      idex_b_q         <= '0;
      idex_imm_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_alu_q      <= '0;
      exmem_store_q    <= '0;
      exmem_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_memtoreg_q <= 1'b0;
      memwb_alu_q      <= '0;
      memwb_rdata_q    <= '0;
      memwb_rd_q       <= '0;
    end else begin
      pc_q             <= pc_d;
      ifid_instr_q     <= ifid_instr_d;
      ifid_pc4_q       <= ifid_pc4_d;
      idex_ctrl_q      <= idex_ctrl_d;
      idex_rs_q        <= idex_rs_d;
      idex_rt_q        <= idex_rt_d;
      idex_dest_q      <= idex_dest_d;
      idex_a_q         <= idex_a_d;
      idex_b_q         <= idex_b_d;
      idex_imm_q       <= idex_imm_d;
      exmem_regwrite_q <= idex_ctrl_q.regwrite;
      exmem_memwrite_q <= idex_ctrl_q.memwrite;
      exmem_memtoreg_q <= idex_ctrl_q.memtoreg;
      exmem_alu_q      <= ex_alu;
      exmem_store_q    <= ex_b_reg;
      exmem_rd_q       <= idex_dest_q;
      memwb_regwrite_q <= exmem_regwrite_q;
      memwb_memtoreg_q <= exmem_memtoreg_q;
      memwb_alu_q      <= exmem_alu_q;
      memwb_rdata_q    <= mem_rdata;
      memwb_rd_q       <= exmem_rd_q;
    end
  end

  // Storage arrays are not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      dmem[lane_addr[0]] <= exmem_store_q[7:0];
      dmem[lane_addr[1]] <= exmem_store_q[15:8];
      dmem[lane_addr[2]] <= exmem_store_q[23:16];
      dmem[lane_addr[3]] <= exmem_store_q[31:24];
    end
    if (wb_we) rf[memwb_rd_q] <= wb_data;
  end

endmodule

// File: tb/tb_pipelined_cpu.sv
// Scoreboard bench for pipelined_cpu: directed programs push expected writebacks/stores into queues,
// a negedge monitor pops and compares them as the core retires them.
module tb_pipelined_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic jump_o, branch_o, data_o, mux8_o;

  pipelined_cpu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .jump_o  (jump_o),
    .branch_o(branch_o),
    .data_o  (data_o),
    .mux8_o  (mux8_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          rd;
    logic [31:0] val;
  } wb_t;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
  } st_t;

  wb_t   wb_q[$];
  st_t   st_q[$];
  wb_t   mon_wb;
  st_t   mon_st;
  int    checks = 0;
  int    errors = 0;
  int    stall_cnt = 0;
  int    flush_cnt = 0;
  int    s0, f0;
  string test_name = "init";

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Writeback and store monitor.
  always @(negedge clk_i) begin
    if (dut.wb_we) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_wb: got r%0d=0x%08h, expected none", test_name,
                 dut.memwb_rd_q, dut.wb_data);
      end else begin
        mon_wb = wb_q.pop_front();
        check($sformatf("%s wb_rd", test_name), 32'(dut.memwb_rd_q), 32'(mon_wb.rd));
        check($sformatf("%s wb r%0d", test_name, mon_wb.rd), dut.wb_data, mon_wb.val);
      end
    end
    if (dut.mem_we) begin
      if (st_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_store: got [0x%02h]=0x%08h, expected none", test_name,
                 dut.mem_addr, dut.exmem_store_q);
      end else begin
        mon_st = st_q.pop_front();
        check($sformatf("%s st_addr", test_name), 32'(dut.mem_addr), 32'(mon_st.addr));
        check($sformatf("%s st_data", test_name), dut.exmem_store_q, mon_st.val);
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (!mux8_o) stall_cnt++;
      if (jump_o || (branch_o && data_o)) flush_cnt++;
    end
  end

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jtype(int addr);
    return {6'h02, 26'(addr)};
  endfunction

  task automatic push_wb(int rd, logic [31:0] val);
    wb_t e;
    e.rd = rd;
    e.val = val;
    wb_q.push_back(e);
  endtask
  task automatic push_st(logic [4:0] addr, logic [31:0] val);
    st_t e;
    e.addr = addr;
    e.val = val;
    st_q.push_back(e);
  endtask

  // Reset with memories cleared; caller loads the program afterwards, still in reset.
  task automatic begin_test(string name);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    test_name = name;
    for (int i = 0; i < 256; i++) dut.imem[i] <= '0;
    for (int i = 0; i < 32; i++) dut.rf[i] <= '0;
    for (int i = 0; i < 32; i++) dut.dmem[i] <= '0;
  endtask

  task automatic release_run();
    @(negedge clk_i);
    rst_i = 1'b1;
    start_i = 1'b1;
    s0 = stall_cnt;
    f0 = flush_cnt;
  endtask

  task automatic end_test(int exp_stalls, int exp_flushes);
    check($sformatf("%s stalls", test_name), 32'(stall_cnt - s0), 32'(exp_stalls));
    check($sformatf("%s flushes", test_name), 32'(flush_cnt - f0), 32'(exp_flushes));
    check($sformatf("%s wb_pending", test_name), 32'(wb_q.size()), 32'd0);
    check($sformatf("%s st_pending", test_name), 32'(st_q.size()), 32'd0);
    wb_q.delete();
    st_q.delete();
  endtask

  function automatic logic [31:0] dword(int a);
    return {dut.dmem[a+3], dut.dmem[a+2], dut.dmem[a+1], dut.dmem[a]};
  endfunction

  initial begin
    logic [31:0] acc;

    // Reset / idle: all-zero program, PC walks by 4, registers untouched.
    begin_test("idle");
    for (int i = 1; i < 32; i++) dut.rf[i] <= 32'h0101_0101 * i;
    release_run();
    check("idle pc_reset", dut.pc_q, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check($sformatf("idle pc_%0d", k), dut.pc_q, 32'(4 * k));
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle pc_hold", dut.pc_q, 32'd16);
    repeat (4) @(negedge clk_i);
    check("idle r5", dut.rf[5], 32'h0505_0505);
    check("idle r31", dut.rf[31], 32'h1F1F_1F1F);
    end_test(0, 0);

    // ALU ops and forwarding (EX/MEM priority, no forwarding from r0).
    begin_test("alu");
    dut.imem[0]  <= itype(6'h08, 0, 8, 5);
    dut.imem[1]  <= itype(6'h08, 0, 9, 3);
    dut.imem[2]  <= rtype(8, 9, 10, 6'h20);
    dut.imem[3]  <= rtype(10, 9, 11, 6'h22);
    dut.imem[4]  <= rtype(10, 8, 12, 6'h18);
    dut.imem[5]  <= itype(6'h08, 0, 13, 1);
    dut.imem[6]  <= itype(6'h08, 0, 13, 2);
    dut.imem[7]  <= rtype(13, 13, 14, 6'h20);
    dut.imem[8]  <= itype(6'h08, 0, 0, 7);
    dut.imem[9]  <= rtype(0, 0, 15, 6'h20);
    dut.imem[10] <= rtype(10, 11, 16, 6'h24);
    dut.imem[11] <= rtype(10, 11, 17, 6'h25);
    push_wb(8, 5);  push_wb(9, 3);  push_wb(10, 8); push_wb(11, 5);
    push_wb(12, 40); push_wb(13, 1); push_wb(13, 2); push_wb(14, 4);
    push_wb(15, 0); push_wb(16, 0); push_wb(17, 13);
    release_run();
    repeat (25) @(negedge clk_i);
    check("alu r10", dut.rf[10], 32'd8);
    check("alu r11", dut.rf[11], 32'd5);
    check("alu r12", dut.rf[12], 32'd40);
    check("alu r0", dut.rf[0], 32'd0);
    end_test(0, 0);

    // Load-use: exactly one stall.
    begin_test("loaduse");
    dut.dmem[0] <= 8'd5;
    dut.imem[0] <= itype(6'h23, 0, 8, 0);
    dut.imem[1] <= rtype(8, 8, 9, 6'h20);
    push_wb(8, 5); push_wb(9, 10);
    release_run();
    repeat (15) @(negedge clk_i);
    check("loaduse r9", dut.rf[9], 32'd10);
    end_test(1, 0);

    // Store with forwarded data.
    begin_test("store");
    for (int i = 4; i < 9; i++) dut.dmem[i] <= 8'hAA;
    dut.imem[0] <= itype(6'h08, 0, 8, 7);
    dut.imem[1] <= itype(6'h2B, 0, 8, 4);
    push_wb(8, 7);
    push_st(5'd4, 32'd7);
    release_run();
    repeat (15) @(negedge clk_i);
    check("store word4", dword(4), 32'h0000_0007);
    check("store byte8", 32'(dut.dmem[8]), 32'h0000_00AA);
    end_test(0, 0);

    // Branch and jump each flush one slot.
    begin_test("flush");
    dut.imem[0] <= itype(6'h04, 0, 0, 1);
    dut.imem[1] <= itype(6'h08, 0, 8, 1);
    dut.imem[2] <= jtype(4);
    dut.imem[3] <= itype(6'h08, 0, 9, 1);
    dut.imem[4] <= itype(6'h08, 0, 10, 2);
    push_wb(10, 2);
    release_run();
    repeat (20) @(negedge clk_i);
    check("flush r8", dut.rf[8], 32'd0);
    check("flush r9", dut.rf[9], 32'd0);
    check("flush r10", dut.rf[10], 32'd2);
    end_test(0, 2);

    // Factorial loop: n=5 from memory, result stored then reloaded.
    begin_test("loop");
    dut.dmem[0]  <= 8'd5;
    dut.imem[0]  <= itype(6'h23, 0, 8, 0);
    dut.imem[1]  <= rtype(8, 0, 14, 6'h20);
    dut.imem[2]  <= itype(6'h08, 0, 9, 1);
    dut.imem[3]  <= itype(6'h04, 8, 0, 4);
    dut.imem[4]  <= rtype(9, 8, 9, 6'h18);
    dut.imem[5]  <= itype(6'h08, 8, 8, -1);
    dut.imem[6]  <= itype(6'h08, 12, 12, 1);
    dut.imem[7]  <= jtype(3);
    dut.imem[8]  <= itype(6'h2B, 0, 9, 8);
    dut.imem[9]  <= itype(6'h23, 0, 15, 8);
    dut.imem[10] <= itype(6'h08, 15, 16, 1);
    push_wb(8, 5); push_wb(14, 5); push_wb(9, 1);
    acc = 1;
    for (int k = 5; k >= 1; k--) begin
      acc = acc * 32'(k);
      push_wb(9, acc);
      push_wb(8, 32'(k - 1));
      push_wb(12, 32'(6 - k));
    end
    push_st(5'd8, acc);
    push_wb(15, acc);
    push_wb(16, acc + 1);
    release_run();
    repeat (90) @(negedge clk_i);
    check("loop r9", dut.rf[9], 32'd120);
    check("loop r12", dut.rf[12], 32'd5);
    check("loop r16", dut.rf[16], 32'd121);
    check("loop mem8", dword(8), 32'd120);
    end_test(2, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
